// File: rtl/fetch_unit.sv
// Instruction fetch unit: a single-outstanding-request fetcher that feeds a
// two-entry {pc, ins} queue ahead of IF/ID, with redirect flush and stale-response drop.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_out_o,
  output logic [31:0] ins_out_o,
  output logic        valid_out_o,
  output logic        flush_out_o
);

  // state | meaning
  // IDLE  | no request outstanding; issue one next cycle if the queue has room
  // REQ   | request for fetch_pc outstanding; its response is pushed
  // DROP  | request outstanding for a pre-redirect address; its response is discarded
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
  logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;

  logic       pop;
  logic       push;
  logic [1:0] cnt_pop;

  always_comb begin
    pop     = (count_q != 2'd0) && !stall_i;
    push    = (state_q == S_REQ) && imem_ack_i && !redirect_i;
    cnt_pop = count_q - {1'b0, pop};

    state_d    = state_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    ins0_d     = ins0_q;
    pc1_d      = pc1_q;
    ins1_d     = ins1_q;
    fetch_pc_d = fetch_pc_q;
    // DROP must keep presenting the abandoned address until its ack arrives
    addr_d     = (state_q == S_DROP) ? addr_q : fetch_pc_q;

    if (redirect_i) begin
      count_d    = 2'd0;
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    end else begin
      case ({push, pop})
        2'b01: begin
          pc0_d   = pc1_q;
          ins0_d  = ins1_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d  = fetch_pc_q;
            ins0_d = imem_data_i;
          end else begin
            pc1_d  = fetch_pc_q;
            ins1_d = imem_data_i;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            pc0_d  = fetch_pc_q;
            ins0_d = imem_data_i;
          end else begin
            pc0_d  = pc1_q;
            ins0_d = ins1_q;
            pc1_d  = fetch_pc_q;
            ins1_d = imem_data_i;
          end
        end
        default: ;
      endcase
      if (push) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    case (state_q)
      S_IDLE: begin
        if (!redirect_i && cnt_pop < 2'd2) state_d = S_REQ;
      end
      S_REQ: begin
        if (redirect_i)      state_d = imem_ack_i ? S_REQ : S_DROP;
        else if (imem_ack_i) state_d = (count_d < 2'd2) ? S_REQ : S_IDLE;
      end
      S_DROP: begin
        // an ack here retires the stale request, so the reloaded fetch_pc can go out
        if (imem_ack_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      count_q    <= 2'd0;
      pc0_q      <= 32'd0;
      ins0_q     <= 32'd0;
      pc1_q      <= 32'd0;
      ins1_q     <= 32'd0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      ins0_q     <= ins0_d;
      pc1_q      <= pc1_d;
      ins1_q     <= ins1_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign imem_req_o  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr_o = (state_q == S_DROP) ? addr_q : fetch_pc_q;
  assign valid_out_o = (count_q != 2'd0);
  assign pc_out_o    = valid_out_o ? pc0_q : 32'd0;
  assign ins_out_o   = valid_out_o ? ins0_q : 32'd0;
  assign flush_out_o = redirect_i & ~rst_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, a slow-memory redirect sequence,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] ins_out;
  logic        valid_out;
  logic        flush_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_data_i(imem_data),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .pc_out_o(pc_out), .ins_out_o(ins_out),
    .valid_out_o(valid_out), .flush_out_o(flush_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_flush;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t vecs[19];

  // reference model: queue contents plus whether a request is out and whether it is stale
  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  bit          m_busy;
  bit          m_stale;

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic a, input logic [31:0] d, input logic s,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ep, input logic [31:0] ei, input logic ef);
    vec_t v;
    v.rst = r; v.redir = rd; v.rpc = rpc; v.ack = a; v.data = d; v.stall = s;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_ins = ei; v.e_flush = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic rd, input logic [31:0] rpc,
                        input logic a, input logic [31:0] d, input logic s);
    rst = r; redirect = rd; redirect_pc = rpc; imem_ack = a; imem_data = d; stall = s;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    set_in(v.rst, v.redir, v.rpc, v.ack, v.data, v.stall);
    #1;
    chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, v.e_req});
    if (v.e_req) chk({tag, ".addr"}, imem_addr, v.e_addr);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v.e_valid});
    chk({tag, ".pc"}, pc_out, v.e_pc);
    chk({tag, ".ins"}, ins_out, v.e_ins);
    chk({tag, ".flush"}, {31'd0, flush_out}, {31'd0, v.e_flush});
    advance();
  endtask

  task automatic model_check();
    logic        ev;
    logic [31:0] ep;
    logic [31:0] ei;
    ev = (mq.size() > 0);
    ep = ev ? mq[0].pc : 32'd0;
    ei = ev ? mq[0].ins : 32'd0;
    chk("rnd.req", {31'd0, imem_req}, {31'd0, m_busy});
    if (m_busy) chk("rnd.addr", imem_addr, m_addr);
    chk("rnd.valid", {31'd0, valid_out}, {31'd0, ev});
    chk("rnd.pc", pc_out, ep);
    chk("rnd.ins", ins_out, ei);
    chk("rnd.flush", {31'd0, flush_out}, {31'd0, redirect & ~rst});
  endtask

  task automatic model_edge();
    logic [31:0] np;
    ent_t        e;
    if (rst) begin
      mq.delete();
      m_fpc = RESET_PC; m_addr = RESET_PC; m_busy = 0; m_stale = 0;
    end else if (redirect) begin
      np = {redirect_pc[31:2], 2'b00};
      mq.delete();
      if (m_busy) begin
        if (imem_ack) begin m_stale = 0; m_addr = np; end
        else m_stale = 1;
      end
      m_fpc = np;
    end else begin
      if (mq.size() > 0 && !stall) e = mq.pop_front();
      if (!m_busy) begin
        if (mq.size() < 2) begin m_busy = 1; m_addr = m_fpc; end
      end else if (m_stale) begin
        if (imem_ack) begin m_stale = 0; m_addr = m_fpc; end
      end else if (imem_ack) begin
        e.pc = m_fpc; e.ins = imem_data;
        mq.push_back(e);
        m_fpc = m_fpc + 32'd4;
        if (mq.size() < 2) m_addr = m_fpc;
        else m_busy = 0;
      end
    end
  endtask

  initial begin
    // rst rd rpc ack data stall | req addr valid pc ins flush
    vecs[0]  = mk(0,0,0,           0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,       0);
    vecs[1]  = mk(0,0,0,           1,32'h0,       0, 1,32'h0,       0,32'h0,       32'h0,       0);
    vecs[2]  = mk(0,0,0,           1,32'h4,       0, 1,32'h4,       1,32'h0,       32'h0,       0);
    vecs[3]  = mk(0,0,0,           1,32'h8,       0, 1,32'h8,       1,32'h4,       32'h4,       0);
    vecs[4]  = mk(0,0,0,           1,32'hC,       1, 1,32'hC,       1,32'h8,       32'h8,       0);
    vecs[5]  = mk(0,0,0,           0,32'h0,       1, 0,32'h0,       1,32'h8,       32'h8,       0);
    vecs[6]  = mk(0,0,0,           0,32'h0,       1, 0,32'h0,       1,32'h8,       32'h8,       0);
    vecs[7]  = mk(0,0,0,           0,32'h0,       0, 0,32'h0,       1,32'h8,       32'h8,       0);
    vecs[8]  = mk(0,0,0,           1,32'h10,      0, 1,32'h10,      1,32'hC,       32'hC,       0);
    vecs[9]  = mk(0,1,32'h203,     1,32'hDEAD,    0, 1,32'h14,      1,32'h10,      32'h10,      1);
    vecs[10] = mk(0,0,0,           0,32'h0,       0, 1,32'h200,     0,32'h0,       32'h0,       0);
    vecs[11] = mk(0,1,32'hFFFFFFFC,0,32'h0,       0, 1,32'h200,     0,32'h0,       32'h0,       1);
    vecs[12] = mk(0,0,0,           1,32'hBAD,     0, 1,32'h200,     0,32'h0,       32'h0,       0);
    vecs[13] = mk(0,0,0,           1,32'h11111111,0, 1,32'hFFFFFFFC,0,32'h0,       32'h0,       0);
    vecs[14] = mk(0,0,0,           1,32'h22,      1, 1,32'h0,       1,32'hFFFFFFFC,32'h11111111,0);
    vecs[15] = mk(0,0,0,           0,32'h0,       0, 0,32'h0,       1,32'hFFFFFFFC,32'h11111111,0);
    vecs[16] = mk(1,1,32'h40,      1,32'h5,       1, 1,32'h4,       1,32'h0,       32'h22,      0);
    vecs[17] = mk(0,0,0,           0,32'h0,       0, 0,32'h0,       0,32'h0,       32'h0,       0);
    vecs[18] = mk(0,0,0,           0,32'h0,       0, 1,RESET_PC,    0,32'h0,       32'h0,       0);

    set_in(1, 0, 0, 0, 0, 0);
    advance();
    advance();
    for (int i = 0; i < 19; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // slow memory: ack in the third request cycle, redirect in the second
    set_in(1, 0, 0, 0, 0, 0);
    advance();
    apply_vec(mk(0,0,0,       0,32'h0,    0, 0,32'h0,   0,32'h0,  32'h0,  0), "slow.idle");
    apply_vec(mk(0,0,0,       0,32'h0,    0, 1,32'h0,   0,32'h0,  32'h0,  0), "slow.w1");
    apply_vec(mk(0,1,32'h100, 0,32'h0,    0, 1,32'h0,   0,32'h0,  32'h0,  1), "slow.w2");
    apply_vec(mk(0,0,0,       1,32'hBAD0, 0, 1,32'h0,   0,32'h0,  32'h0,  0), "slow.stale");
    apply_vec(mk(0,0,0,       1,32'h100,  0, 1,32'h100, 0,32'h0,  32'h0,  0), "slow.new");
    apply_vec(mk(0,0,0,       0,32'h0,    0, 1,32'h104, 1,32'h100,32'h100,0), "slow.head");

    set_in(1, 0, 0, 0, 0, 0);
    advance();
    model_edge();
    for (int i = 0; i < 3000; i++) begin
      logic a;
      if (m_busy) a = (i < 1500) ? 1'b1 : ($urandom_range(0, 2) == 0);
      else        a = 1'b0;
      set_in($urandom_range(0, 149) == 0, $urandom_range(0, 11) == 0, $urandom,
             a, $urandom, $urandom_range(0, 2) == 0);
      #1;
      model_check();
      advance();
      model_edge();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the first instruction address fetched after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 imem_req  output  1  instruction-memory request; high while a fetch is outstanding.
REQ-005 imem_addr  output  32  word-aligned fetch address; stable while imem_req=1.
REQ-006 imem_ack  input  1  single-cycle acknowledge; imem_data valid in the same cycle.
REQ-007 imem_data  input  32  instruction word returned with imem_ack.
REQ-008 stall  input  1  decode-side hold (IF/ID write=0); head entry is not consumed.
REQ-009 redirect  input  1  branch/jump taken; discard all fetched and in-flight instructions.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 pc_out  output  32  address of the head instruction, to IF/ID pc_in.
REQ-012 ins_out  output  32  head instruction word, to IF/ID ins_in.
REQ-013 valid_out  output  1  head entry present; IF/ID write enable source.
REQ-014 flush_out  output  1  IF/ID flush; equals redirect & ~rst.

Function
REQ-015 Queue: 2 entries of {pc, ins}, FIFO order; count 0..2.
REQ-016 FSM states IDLE, REQ, DROP; imem_req=1 in REQ and DROP only.
REQ-017 IDLE->REQ when count (after this cycle's pop) < 2; imem_addr=fetch_pc.
REQ-018 REQ with imem_ack: push {fetch_pc, imem_data}; fetch_pc += 4 mod 2^32; stay REQ if post-push/pop count < 2, else IDLE.
REQ-019 REQ without imem_ack: hold imem_req and imem_addr unchanged.
REQ-020 At most one outstanding request; an outstanding request is never withdrawn.
REQ-021 Pop when valid_out=1 and stall=0; push and pop in the same cycle are both honoured.
REQ-022 valid_out=1 iff count>0; when count=0, pc_out=0 and ins_out=0 (NOP).
REQ-023 Redirect in IDLE: clear queue, fetch_pc=redirect_pc with bits[1:0] forced to 00, next state IDLE (request issued per REQ-017).
REQ-024 Redirect in REQ without ack: clear queue, load fetch_pc, go DROP; the pending response is discarded.
REQ-025 Redirect in REQ with ack in the same cycle: ack data discarded, queue cleared, fetch_pc loaded, next state REQ at redirect address.
REQ-026 DROP: imem_addr holds the stale address; on imem_ack discard data and go REQ at fetch_pc; redirect in DROP reloads fetch_pc and stays DROP.
REQ-027 Redirect overrides any same-cycle pop or push; stall has no effect on the flush.
REQ-028 Throughput: with zero-wait memory (ack in the request cycle) and stall=0, one instruction per cycle.
REQ-029 Latency: instruction acked in cycle N appears on pc_out/ins_out with valid_out=1 in cycle N+1.

Reset
REQ-030 rst=1 at a clock edge: count=0, state IDLE, fetch_pc=RESET_PC, imem_req=0, valid_out=0, pc_out=0, ins_out=0, flush_out=0.
REQ-031 Reset has priority over redirect, ack, and stall.
REQ-032 Reset mid-request abandons the request; any imem_ack in the cycle rst is sampled is ignored.
REQ-033 imem_req first rises one cycle after the cycle in which rst is released.

Verification
REQ-034 Reset release, zero-wait memory returning addr as data, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; pc_out/ins_out 0,4,8 from the following cycle, one per cycle.
REQ-035 stall=1 for 3 cycles with zero-wait memory -> queue fills to 2, then imem_req=0; head value is held; on stall release, 2 queued entries drain in order and fetching resumes.
REQ-036 Memory with 3-cycle ack, redirect_pc=0x100 asserted in the 2nd wait cycle -> flush_out=1 that cycle; stale data is dropped; next imem_addr=0x100; first valid pc_out=0x100.
REQ-037 Redirect and imem_ack in the same cycle, redirect_pc=0x203 -> ack data discarded; next imem_addr=0x200; queue empty.
REQ-038 fetch_pc=0xFFFF_FFFC acked -> pc_out=0xFFFF_FFFC, next imem_addr=0x0000_0000.
REQ-039 rst asserted while imem_req=1 with imem_ack=1 -> no push; all outputs 0; imem_addr=RESET_PC when imem_req rises again.
